debug_reg_reader: RTL and testbench

//  Host-side readout for the pipeline debug taps (SpMM, DMVM, softmax, aggregator).

---
 rtl/debug_reg_reader.sv | 139 +++++++++++++
 tb/tb_debug_reg_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_reader.sv
// Sticky per-stage start/done flags and busy-cycle counters for the pipeline debug taps,
// snapshotted into shadow registers and read one word at a time over a valid/ready port.
module debug_reg_reader #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_vld_i,
    input  logic [NUM_STAGES-1:0] stage_rdy_i,
    input  logic [DATA_W-1:0]     debug_1_i,
    input  logic [DATA_W-1:0]     debug_2_i,
    input  logic [DATA_W-1:0]     debug_3_i,
    input  logic                  snap_req_i,
    input  logic                  rd_vld_i,
    output logic                  rd_rdy_o,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_data_vld_o,
    input  logic                  rd_data_rdy_i,
    output logic [15:0]           snap_cnt_o
);

    typedef enum logic [1:0] {IDLE, SNAP, RESP} state_t;

    state_t                  state;
    logic                    snap_pend;
    logic [NUM_STAGES-1:0]   started;
    logic [NUM_STAGES-1:0]   done;
    logic [NUM_STAGES-1:0]   running;
    logic [NUM_STAGES-1:0]   run_next;
    logic [CNT_W-1:0]        cnt      [NUM_STAGES];
    logic [DATA_W-1:0]       cnt_word [NUM_STAGES];
    logic [DATA_W-1:0]       shadow   [8];
    logic [DATA_W-1:0]       status;
    logic [DATA_W-1:0]       rd_mux;

    // A done pulse always ends the run, even when it coincides with a start pulse.
    assign run_next = ~stage_rdy_i & (running | stage_vld_i);

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            status[2*i]   = started[i];
            status[2*i+1] = done[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            cnt_word[i] = DATA_W'(cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started <= '0;
            done    <= '0;
            running <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            started <= started | stage_vld_i;
            done    <= done | stage_rdy_i;
            running <= run_next;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (run_next[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Addresses 8 and 9 are live views; everything below 8 comes from the shadow set.
    always_comb begin
        rd_mux = DATA_W'(32'hDEAD_BEEF);
        if (rd_addr_i < ADDR_W'(8)) begin
            rd_mux = shadow[rd_addr_i[2:0]];
        end else if (rd_addr_i == ADDR_W'(8)) begin
            rd_mux = DATA_W'(snap_cnt_o);
        end else if (rd_addr_i == ADDR_W'(9)) begin
            rd_mux = status;
        end
    end

    assign rd_rdy_o = !rst && (state == IDLE) && !snap_req_i && !snap_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            snap_pend     <= 1'b0;
            snap_cnt_o    <= '0;
            rd_data_o     <= '0;
            rd_data_vld_o <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (snap_req_i || snap_pend) begin
                        state <= SNAP;
                    end else if (rd_vld_i) begin
                        rd_data_o     <= rd_mux;
                        rd_data_vld_o <= 1'b1;
                        state         <= RESP;
                    end
                end
                SNAP: begin
                    shadow[0] <= debug_1_i;
                    shadow[1] <= debug_2_i;
                    shadow[2] <= debug_3_i;
                    shadow[3] <= status;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        shadow[4+i] <= cnt_word[i];
                    end
                    snap_cnt_o <= snap_cnt_o + 16'd1;
                    // A request landing in the capture cycle is kept for the next snapshot.
                    snap_pend  <= snap_req_i;
                    state      <= IDLE;
                end
                RESP: begin
                    if (snap_req_i) begin
                        snap_pend <= 1'b1;
                    end
                    if (rd_data_rdy_i) begin
                        rd_data_vld_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_reg_reader.sv
// Bench for debug_reg_reader: directed scenarios plus randomized stage activity checked
// against a cycle-level behavioural model of flags, busy counts and snapshots.
module tb_debug_reg_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stage_vld, stage_rdy;
    logic [31:0] debug_1, debug_2, debug_3;
    logic        snap_req, rd_vld, rd_rdy, rd_data_vld, rd_data_rdy;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] snap_cnt;

    logic [3:0]  s_vld, s_rdy, s_addr;
    logic        s_snap, s_rd_vld, s_rd_rdy, s_data_vld, s_data_rdy;
    logic [31:0] s_data;
    logic [15:0] s_snap_cnt;

    int checks = 0;
    int errors = 0;
    bit rand_on = 0;

    logic [3:0]  m_started, m_done, m_run;
    longint      m_cnt [4];
    logic [31:0] m_shadow [8];
    int          m_snaps;

    always #5 clk = ~clk;

    debug_reg_reader dut (
        .clk(clk), .rst(rst), .stage_vld_i(stage_vld), .stage_rdy_i(stage_rdy),
        .debug_1_i(debug_1), .debug_2_i(debug_2), .debug_3_i(debug_3),
        .snap_req_i(snap_req), .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_data_vld_o(rd_data_vld), .rd_data_rdy_i(rd_data_rdy),
        .snap_cnt_o(snap_cnt)
    );

    debug_reg_reader #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stage_vld_i(s_vld), .stage_rdy_i(s_rdy),
        .debug_1_i(32'h0), .debug_2_i(32'h0), .debug_3_i(32'h0),
        .snap_req_i(s_snap), .rd_vld_i(s_rd_vld), .rd_rdy_o(s_rd_rdy), .rd_addr_i(s_addr),
        .rd_data_o(s_data), .rd_data_vld_o(s_data_vld), .rd_data_rdy_i(s_data_rdy),
        .snap_cnt_o(s_snap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_started = '0; m_done = '0; m_run = '0; m_snaps = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        for (int k = 0; k < 8; k++) m_shadow[k] = '0;
    endfunction

    // A stage is busy for every cycle it ends in the running condition.
    function automatic void model_step(input logic [3:0] v, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) m_started[i] = 1'b1;
            if (r[i]) m_done[i] = 1'b1;
            if (r[i]) m_run[i] = 1'b0;
            else if (v[i]) m_run[i] = 1'b1;
            if (m_run[i] && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
        end
    endfunction

    function automatic logic [31:0] model_status();
        int s = 0;
        for (int i = 0; i < 4; i++) s += (int'(m_started[i]) << (2*i)) + (int'(m_done[i]) << (2*i+1));
        return 32'(s);
    endfunction

    function automatic logic [31:0] exp_reg(input logic [3:0] a);
        if (a < 8) return m_shadow[a];
        if (a == 8) return 32'(m_snaps % 65536);
        if (a == 9) return model_status();
        return 32'hDEAD_BEEF;
    endfunction

    function automatic void model_capture();
        m_shadow[0] = debug_1; m_shadow[1] = debug_2; m_shadow[2] = debug_3;
        m_shadow[3] = model_status();
        for (int i = 0; i < 4; i++) m_shadow[4+i] = 32'(m_cnt[i]);
        m_snaps++;
    endfunction

    task automatic clk_cycle();
        if (rand_on) begin
            for (int i = 0; i < 4; i++) begin
                stage_vld[i] = ($urandom_range(0, 5) == 0);
                stage_rdy[i] = ($urandom_range(0, 9) == 0);
            end
        end
        if (rst) model_reset();
        else model_step(stage_vld, stage_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input string tag);
        logic [31:0] exp;
        int n = 0;
        rd_vld = 1'b1; rd_addr = a;
        #1;
        while (!rd_rdy && n < 20) begin
            clk_cycle();
            n++;
        end
        check({tag, "_accept"}, 32'(rd_rdy), 32'd1);
        exp = exp_reg(a);
        clk_cycle();
        rd_vld = 1'b0;
        check({tag, "_vld"}, 32'(rd_data_vld), 32'd1);
        check(tag, rd_data, exp);
        rd_data_rdy = 1'b1;
        clk_cycle();
        rd_data_rdy = 1'b0;
        check({tag, "_vld_drop"}, 32'(rd_data_vld), 32'd0);
    endtask

    task automatic do_snap(input string tag);
        snap_req = 1'b1;
        debug_1 = $urandom; debug_2 = $urandom; debug_3 = $urandom;
        clk_cycle();
        snap_req = 1'b0;
        model_capture();
        clk_cycle();
        check(tag, 32'(snap_cnt), 32'(m_snaps % 65536));
    endtask

    task automatic sat_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sat_snap();
        s_snap = 1'b1; sat_cycle();
        s_snap = 1'b0; sat_cycle(); sat_cycle();
    endtask

    task automatic sat_read(input logic [3:0] a, output logic [31:0] d);
        s_rd_vld = 1'b1; s_addr = a; sat_cycle();
        s_rd_vld = 1'b0; d = s_data;
        s_data_rdy = 1'b1; sat_cycle();
        s_data_rdy = 1'b0;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=no_finish expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held, d;
        rst = 1'b1; stage_vld = '0; stage_rdy = '0; snap_req = 1'b0;
        debug_1 = 32'h1111_1111; debug_2 = 32'h2222_2222; debug_3 = 32'h3333_3333;
        rd_vld = 1'b0; rd_addr = '0; rd_data_rdy = 1'b0;
        s_vld = '0; s_rdy = '0; s_snap = 1'b0; s_rd_vld = 1'b0; s_addr = '0; s_data_rdy = 1'b0;
        model_reset();

        // Reset state
        repeat (3) clk_cycle();
        check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check("rst_data_vld", 32'(rd_data_vld), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_snap_cnt", 32'(snap_cnt), 32'd0);
        rst = 1'b0;
        clk_cycle();
        check("post_rst_rd_rdy", 32'(rd_rdy), 32'd1);
        for (int a = 0; a < 10; a++) do_read(4'(a), $sformatf("rst_read_%0d", a));
        do_read(4'd12, "unmapped_12");
        check("unmapped_const", rd_data, 32'hDEAD_BEEF);

        // Busy-cycle count for stage 1 over ten cycles
        stage_vld = 4'b0010; clk_cycle();
        stage_vld = 4'b0000;
        repeat (9) clk_cycle();
        stage_rdy = 4'b0010; clk_cycle();
        stage_rdy = 4'b0000;
        do_snap("t2_snap_cnt");
        do_read(4'd5, "t2_cnt1");
        check("t2_cnt1_const", rd_data, 32'd10);
        do_read(4'd3, "t2_status");
        check("t2_status_const", rd_data, 32'h0000_000C);

        // Snapshot and read requested in the same idle cycle
        debug_1 = $urandom; debug_2 = $urandom; debug_3 = $urandom;
        snap_req = 1'b1; rd_vld = 1'b1; rd_addr = 4'd0;
        #1;
        check("t3_rdy_blocked", 32'(rd_rdy), 32'd0);
        clk_cycle();
        snap_req = 1'b0;
        model_capture();
        #1;
        check("t3_rdy_in_snap", 32'(rd_rdy), 32'd0);
        clk_cycle();
        check("t3_rdy_after_snap", 32'(rd_rdy), 32'd1);
        held = exp_reg(4'd0);
        clk_cycle();
        rd_vld = 1'b0;
        check("t3_data_new_snap", rd_data, held);
        check("t3_snap_cnt", 32'(snap_cnt), 32'(m_snaps));
        rd_data_rdy = 1'b1; clk_cycle(); rd_data_rdy = 1'b0;

        // Back-pressure with two merged snapshot requests
        rd_vld = 1'b1; rd_addr = 4'd1;
        held = exp_reg(4'd1);
        clk_cycle();
        rd_vld = 1'b0;
        check("t4_data", rd_data, held);
        for (int k = 0; k < 5; k++) begin
            snap_req = (k == 1 || k == 3);
            clk_cycle();
            check($sformatf("t4_stable_%0d", k), rd_data, held);
            check($sformatf("t4_vld_%0d", k), 32'(rd_data_vld), 32'd1);
        end
        snap_req = 1'b0;
        debug_1 = $urandom; debug_2 = $urandom; debug_3 = $urandom;
        rd_data_rdy = 1'b1; clk_cycle(); rd_data_rdy = 1'b0;
        check("t4_pend_blocks_rdy", 32'(rd_rdy), 32'd0);
        model_capture();
        repeat (4) clk_cycle();
        check("t4_one_snap", 32'(snap_cnt), 32'(m_snaps));
        do_read(4'd0, "t4_new_dbg1");
        do_read(4'd8, "t4_live_snap_cnt");

        // Randomized stage activity with periodic snapshots and reads
        rand_on = 1;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(3, 25)) clk_cycle();
            do_snap($sformatf("rnd_snap_%0d", it));
            for (int r = 0; r < 3; r++) do_read(4'($urandom_range(0, 15)), $sformatf("rnd_rd_%0d_%0d", it, r));
            do_read(4'($urandom_range(3, 7)), $sformatf("rnd_stage_%0d", it));
        end
        rand_on = 0;
        stage_vld = '0; stage_rdy = '0;

        // Reset while a response is outstanding
        rd_vld = 1'b1; rd_addr = 4'd0;
        clk_cycle();
        rd_vld = 1'b0;
        check("t6_in_resp", 32'(rd_data_vld), 32'd1);
        rst = 1'b1;
        clk_cycle();
        check("t6_vld_dropped", 32'(rd_data_vld), 32'd0);
        check("t6_snap_cnt", 32'(snap_cnt), 32'd0);
        check("t6_rdy_in_rst", 32'(rd_rdy), 32'd0);
        rst = 1'b0;
        clk_cycle();
        for (int a = 0; a < 10; a++) do_read(4'(a), $sformatf("t6_read_%0d", a));

        // Saturating 4-bit counters
        s_vld = 4'b0001; s_rdy = 4'b0001; sat_cycle();
        s_vld = '0; s_rdy = '0;
        sat_snap();
        sat_read(4'd4, d); check("sat_same_cycle_cnt", d, 32'd0);
        sat_read(4'd3, d); check("sat_same_cycle_status", d, 32'h0000_0003);
        s_vld = 4'b0001; sat_cycle();
        s_vld = '0;
        repeat (20) sat_cycle();
        sat_snap();
        sat_read(4'd4, d); check("sat_cnt_full", d, 32'h0000_000F);
        s_vld = 4'b0001; s_rdy = 4'b0001; sat_cycle();
        s_vld = '0; s_rdy = '0;
        repeat (3) sat_cycle();
        sat_snap();
        sat_read(4'd4, d); check("sat_cnt_held", d, 32'h0000_000F);
        sat_read(4'd3, d); check("sat_status", d, 32'h0000_0003);
        sat_read(4'd8, d); check("sat_snap_cnt", d, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
